r5_lane_serializer: RTL

//  Consumer-side end of the radix-5 butterfly output register stage: accepts one
//  5-lane complex vector per handshake and streams it out one complex sample per beat.

---
 rtl/fft_r5_pkg.sv | 19 +
 rtl/r5_lane_serializer.sv | 95 +++++++++
 2 files changed

// File: rtl/fft_r5_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : fft_r5_pkg
//  Purpose  : Shared widths and FSM encoding for the radix-5 FFT output path.
//  Revision : 1.0  initial release
// ============================================================================
package fft_r5_pkg;

  localparam int DW          = 32;
  localparam int LANES       = 5;
  localparam int RADIX_IDX_W = 3;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage : fft_r5_pkg
`default_nettype wire

// File: rtl/r5_lane_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : r5_lane_serializer
//  Purpose  : Takes one 5-lane complex vector per handshake and streams it out
//             one complex sample per clock, with no bubble between vectors.
//  Revision : 1.0  initial release
// ============================================================================
module r5_lane_serializer #(
  parameter int DW    = 32,
  parameter int LANES = 5,
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_re,
  input  logic [LANES*DW-1:0] in_img,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_re,
  output logic [DW-1:0]       out_img,
  output logic [2:0]          out_idx,
  output logic                out_last,
  output logic [CW-1:0]       vec_cnt
);

  import fft_r5_pkg::*;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [RADIX_IDX_W-1:0] r_idx;
  logic [RADIX_IDX_W-1:0] w_idx_nxt;
  logic [DW-1:0]          r_hold [LANES][2];
  logic [CW-1:0]          r_vec_cnt;

  logic w_drain;
  logic w_last_lane;
  logic w_accept;
  logic w_beat;

  assign w_drain     = (r_state == DRAIN);
  assign w_last_lane = (r_idx == RADIX_IDX_W'(LANES - 1));
  // Refill is allowed in the same cycle the final lane leaves.
  assign in_ready    = !w_drain || (w_last_lane && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_beat      = w_drain && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_accept) begin
      w_state_nxt = DRAIN;
      w_idx_nxt   = '0;
    end else if (w_beat) begin
      if (w_last_lane) begin
        w_state_nxt = EMPTY;
      end else begin
        w_idx_nxt = r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_idx     <= '0;
      r_vec_cnt <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_hold[k][0] <= '0;
        r_hold[k][1] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_vec_cnt <= r_vec_cnt + 1'b1;
        for (int k = 0; k < LANES; k++) begin
          r_hold[k][0] <= in_re[k*DW +: DW];
          r_hold[k][1] <= in_img[k*DW +: DW];
        end
      end
    end
  end

  // In EMPTY the index still points at the last lane sent, so data holds its value.
  assign out_valid = w_drain;
  assign out_re    = r_hold[r_idx][0];
  assign out_img   = r_hold[r_idx][1];
  assign out_idx   = w_drain ? r_idx : 3'd0;
  assign out_last  = w_drain && w_last_lane;
  assign vec_cnt   = r_vec_cnt;

endmodule : r5_lane_serializer
`default_nettype wire
